// File: rtl/car_winker_seq.sv
// Turn-signal controller: LEFT/RIGHT/HAZARD modes with a thermometer LED sweep and frame auto-cancel.
// Outputs are decoded from registered state only; single-cycle request pulses are acted on at the next edge.
module car_winker_seq #(
  parameter int CLK_DIV   = 4,
  parameter int LED_N     = 3,
  parameter int BLINK_MAX = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             left_winker,
  input  logic             right_winker,
  input  logic             hazard,
  input  logic             off,
  output logic             o_standby,
  output logic             o_left_winker,
  output logic             o_right_winker,
  output logic             o_hazard,
  output logic             o_finish_mode,
  output logic [LED_N-1:0] o_left_led,
  output logic [LED_N-1:0] o_right_led,
  output logic [7:0]       o_blink_cnt
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int STEP_W = $clog2(LED_N + 1);

  typedef enum logic [2:0] {IDLE, STANDBY, LEFT, RIGHT, HAZARD, FINISH} state_t;

  state_t             state, state_nx;
  logic [DIV_W-1:0]   div, div_nx;
  logic [STEP_W-1:0]  step, step_nx;
  logic [7:0]         blink_cnt, blink_nx, blink_inc;
  logic               tick, wrap, auto_cancel, run, both, entry;
  logic [LED_N-1:0]   therm;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      div       <= '0;
      step      <= '0;
      blink_cnt <= '0;
    end else begin
      state     <= state_nx;
      div       <= div_nx;
      step      <= step_nx;
      blink_cnt <= blink_nx;
    end
  end

  always_comb begin
    tick        = (div == DIV_W'(CLK_DIV - 1));
    wrap        = tick && (step == STEP_W'(LED_N));
    blink_inc   = (blink_cnt == 8'd255) ? blink_cnt : blink_cnt + 8'd1;
    auto_cancel = (BLINK_MAX != 0) && wrap && (blink_inc == 8'(BLINK_MAX));
    both        = hazard || (left_winker && right_winker);
    run         = 1'b0;
    state_nx    = state;

    case (state)
      IDLE:    state_nx = STANDBY;
      FINISH:  if (!off) state_nx = IDLE;
      STANDBY: begin
        if (both)              state_nx = HAZARD;
        else if (left_winker)  state_nx = LEFT;
        else if (right_winker) state_nx = RIGHT;
      end
      LEFT: begin
        if (both)              state_nx = HAZARD;
        else if (left_winker)  state_nx = STANDBY;
        else if (right_winker) state_nx = RIGHT;
        else begin
          run = 1'b1;
          if (auto_cancel) state_nx = STANDBY;
        end
      end
      RIGHT: begin
        if (both)              state_nx = HAZARD;
        else if (right_winker) state_nx = STANDBY;
        else if (left_winker)  state_nx = LEFT;
        else begin
          run = 1'b1;
          if (auto_cancel) state_nx = STANDBY;
        end
      end
      HAZARD: begin
        if (hazard) state_nx = STANDBY;
        else        run = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    // ignition-off overrides every request once past the IDLE step
    if (off && state != IDLE) begin
      state_nx = FINISH;
      run      = 1'b0;
    end

    div_nx   = div;
    step_nx  = step;
    blink_nx = blink_cnt;
    if (run) begin
      div_nx = tick ? '0 : div + DIV_W'(1);
      if (tick) step_nx = wrap ? '0 : step + STEP_W'(1);
      if (wrap) blink_nx = blink_inc;
    end

    entry = (state_nx != state) &&
            (state_nx == LEFT || state_nx == RIGHT || state_nx == HAZARD);
    if (entry || state_nx == IDLE) begin
      div_nx   = '0;
      step_nx  = '0;
      blink_nx = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < LED_N; i++) therm[i] = (i < int'(step));
    o_standby      = (state == STANDBY);
    o_left_winker  = (state == LEFT);
    o_right_winker = (state == RIGHT);
    o_hazard       = (state == HAZARD);
    o_finish_mode  = (state == FINISH);
    o_left_led     = (state == LEFT  || state == HAZARD) ? therm : '0;
    o_right_led    = (state == RIGHT || state == HAZARD) ? therm : '0;
    o_blink_cnt    = blink_cnt;
  end

endmodule

// File: tb/tb_car_winker_seq.sv
// Directed bench for car_winker_seq: default instance plus an LED_N=1/CLK_DIV=2/no-cancel instance.
module tb_car_winker_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, left_winker, right_winker, hazard, off;
  logic a_sb, a_l, a_r, a_h, a_f;
  logic [2:0] a_lled, a_rled;
  logic [7:0] a_bc;

  logic rst_b_n, b_left, b_right, b_hazard, b_off;
  logic b_sb, b_l, b_r, b_h, b_f;
  logic [0:0] b_lled, b_rled;
  logic [7:0] b_bc;

  car_winker_seq dut_a (
    .clk(clk), .reset_n(reset_n), .left_winker(left_winker), .right_winker(right_winker),
    .hazard(hazard), .off(off), .o_standby(a_sb), .o_left_winker(a_l), .o_right_winker(a_r),
    .o_hazard(a_h), .o_finish_mode(a_f), .o_left_led(a_lled), .o_right_led(a_rled),
    .o_blink_cnt(a_bc)
  );

  car_winker_seq #(.CLK_DIV(2), .LED_N(1), .BLINK_MAX(0)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .left_winker(b_left), .right_winker(b_right),
    .hazard(b_hazard), .off(b_off), .o_standby(b_sb), .o_left_winker(b_l), .o_right_winker(b_r),
    .o_hazard(b_h), .o_finish_mode(b_f), .o_left_led(b_lled), .o_right_led(b_rled),
    .o_blink_cnt(b_bc)
  );

  localparam logic [4:0] M_IDLE = 5'b00000, M_SB = 5'b10000, M_L = 5'b01000,
                         M_R = 5'b00100, M_H = 5'b00010, M_F = 5'b00001;

  int checks = 0;
  int errors = 0;
  logic [18:0] sb_a[$];
  logic [14:0] sb_b[$];

  function automatic logic [2:0] therm3(input int s);
    return 3'((1 << s) - 1);
  endfunction

  task automatic cyc_a(input string tag, input logic [4:0] m, input logic [2:0] ll,
                       input logic [2:0] rl, input logic [7:0] bc);
    logic [18:0] obs, exp;
    sb_a.push_back({m, ll, rl, bc});
    @(posedge clk); #1;
    left_winker = 1'b0; right_winker = 1'b0; hazard = 1'b0;
    exp = sb_a.pop_front();
    obs = {a_sb, a_l, a_r, a_h, a_f, a_lled, a_rled, a_bc};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc_b(input string tag, input logic [4:0] m, input logic ll,
                       input logic [7:0] bc);
    logic [14:0] obs, exp;
    sb_b.push_back({m, ll, 1'b0, bc});
    @(posedge clk); #1;
    b_left = 1'b0;
    exp = sb_b.pop_front();
    obs = {b_sb, b_l, b_r, b_h, b_f, b_lled, b_rled, b_bc};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; left_winker = 1'b0; right_winker = 1'b0; hazard = 1'b0; off = 1'b0;
    rst_b_n = 1'b0; b_left = 1'b0; b_right = 1'b0; b_hazard = 1'b0; b_off = 1'b0;

    // reset and release
    cyc_a("reset0", M_IDLE, 3'b0, 3'b0, 8'd0);
    cyc_a("reset1", M_IDLE, 3'b0, 3'b0, 8'd0);
    reset_n = 1'b1; rst_b_n = 1'b1;
    cyc_a("standby_after_release", M_SB, 3'b0, 3'b0, 8'd0);

    // left sweep, two frames, auto-cancel
    left_winker = 1'b1;
    for (int k = 0; k < 32; k++)
      cyc_a($sformatf("left_sweep_k%0d", k), M_L, therm3((k % 16) / 4), 3'b0, 8'(k / 16));
    cyc_a("left_autocancel", M_SB, 3'b0, 3'b0, 8'd2);
    cyc_a("standby_holds_cnt", M_SB, 3'b0, 3'b0, 8'd2);

    // left then switch to right at step 2
    left_winker = 1'b1;
    for (int k = 0; k < 10; k++)
      cyc_a($sformatf("left2_k%0d", k), M_L, therm3(k / 4), 3'b0, 8'd0);
    right_winker = 1'b1;
    cyc_a("switch_to_right", M_R, 3'b0, 3'b0, 8'd0);
    for (int k = 1; k < 6; k++)
      cyc_a($sformatf("right_k%0d", k), M_R, 3'b0, therm3(k / 4), 8'd0);

    // ignition off mid-RIGHT
    off = 1'b1;
    cyc_a("finish_enter", M_F, 3'b0, 3'b0, 8'd0);
    for (int k = 0; k < 10; k++)
      cyc_a($sformatf("finish_hold_%0d", k), M_F, 3'b0, 3'b0, 8'd0);
    off = 1'b0;
    cyc_a("finish_to_idle", M_IDLE, 3'b0, 3'b0, 8'd0);
    cyc_a("idle_to_standby", M_SB, 3'b0, 3'b0, 8'd0);

    // hazard for 5+ frames, left pulse ignored, hazard pulse cancels
    hazard = 1'b1;
    for (int k = 0; k < 86; k++) begin
      if (k == 40) left_winker = 1'b1;
      cyc_a($sformatf("hazard_k%0d", k), M_H, therm3((k % 16) / 4), therm3((k % 16) / 4),
            8'(k / 16));
    end
    hazard = 1'b1;
    cyc_a("hazard_cancel", M_SB, 3'b0, 3'b0, 8'd5);

    // left+right together -> hazard, then reset mid-hazard
    left_winker = 1'b1; right_winker = 1'b1;
    for (int k = 0; k < 7; k++)
      cyc_a($sformatf("lr_hazard_k%0d", k), M_H, therm3(k / 4), therm3(k / 4), 8'd0);
    reset_n = 1'b0;
    cyc_a("reset_mid_hazard", M_IDLE, 3'b0, 3'b0, 8'd0);
    reset_n = 1'b1;
    cyc_a("standby_after_reset", M_SB, 3'b0, 3'b0, 8'd0);

    // request on the auto-cancel edge wins over the cancel
    left_winker = 1'b1;
    for (int k = 0; k < 32; k++)
      cyc_a($sformatf("left3_k%0d", k), M_L, therm3((k % 16) / 4), 3'b0, 8'(k / 16));
    right_winker = 1'b1;
    cyc_a("request_beats_autocancel", M_R, 3'b0, 3'b0, 8'd0);

    // LED_N=1, CLK_DIV=2, no auto-cancel: 0,0,1,1 indefinitely
    b_left = 1'b1;
    for (int k = 0; k < 40; k++)
      cyc_b($sformatf("b_blink_k%0d", k), M_L, ((k % 4) >= 2), 8'(k / 4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
